// File: rtl/move_stack_ctrl.sv
// Move-history LIFO for one ant: arbitrates push, pop and full-stack rewind.
// All outputs are registered; requests get their response one cycle later.
module move_stack_ctrl #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = 5,
    parameter int unsigned MW    = 3
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          push_req,
    input  logic [MW-1:0] push_move,
    input  logic          pop_req,
    input  logic          rewind_req,
    output logic          push_ack,
    output logic          pop_valid,
    output logic [MW-1:0] pop_move,
    output logic          rewind_busy,
    output logic          rewind_done,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          overflow_err,
    output logic          underflow_err
);

    typedef enum logic [1:0] {StIdle, StRewind, StDone} state_e;

    localparam logic [AW:0]   OneC   = 1;
    localparam logic [AW:0]   DepthC = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] OneA   = 1;

    logic [MW-1:0] mem [DEPTH];

    state_e        state, state_nxt;
    logic [AW:0]   count_nxt;
    logic [AW-1:0] top_idx, waddr;
    logic          we;
    logic [MW-1:0] pm_nxt;
    logic          ack_nxt, pv_nxt, busy_nxt, done_nxt, ovf_nxt, unf_nxt;

    // Index 31 when count==32 falls out of the wrap of the low AW bits.
    assign top_idx = count[AW-1:0] - OneA;

    always_comb begin
        state_nxt = state;
        count_nxt = count;
        we        = 1'b0;
        waddr     = count[AW-1:0];
        pm_nxt    = pop_move;
        ack_nxt   = 1'b0;
        pv_nxt    = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        ovf_nxt   = overflow_err;
        unf_nxt   = underflow_err;
        unique case (state)
            StIdle: begin
                if (rewind_req) begin
                    if (count == '0) begin
                        done_nxt = 1'b1;
                    end else begin
                        pm_nxt    = mem[top_idx];
                        pv_nxt    = 1'b1;
                        busy_nxt  = 1'b1;
                        count_nxt = count - OneC;
                        state_nxt = StRewind;
                    end
                end else if (push_req && pop_req) begin
                    ack_nxt = 1'b1;
                    we      = 1'b1;
                    if (count == '0) begin
                        count_nxt = OneC;
                        unf_nxt   = 1'b1;
                    end else begin
                        // Replace top: old value is read before the write lands.
                        waddr  = top_idx;
                        pm_nxt = mem[top_idx];
                        pv_nxt = 1'b1;
                    end
                end else if (push_req) begin
                    if (count == DepthC) begin
                        ovf_nxt = 1'b1;
                    end else begin
                        we        = 1'b1;
                        ack_nxt   = 1'b1;
                        count_nxt = count + OneC;
                    end
                end else if (pop_req) begin
                    if (count == '0) begin
                        unf_nxt = 1'b1;
                    end else begin
                        pm_nxt    = mem[top_idx];
                        pv_nxt    = 1'b1;
                        count_nxt = count - OneC;
                    end
                end
            end
            StRewind: begin
                if (count != '0) begin
                    pm_nxt    = mem[top_idx];
                    pv_nxt    = 1'b1;
                    busy_nxt  = 1'b1;
                    count_nxt = count - OneC;
                end else begin
                    done_nxt  = 1'b1;
                    state_nxt = StDone;
                end
            end
            StDone: state_nxt = StIdle;
            default: state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= push_move;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= StIdle;
            count         <= '0;
            push_ack      <= 1'b0;
            pop_valid     <= 1'b0;
            pop_move      <= '0;
            rewind_busy   <= 1'b0;
            rewind_done   <= 1'b0;
            full          <= 1'b0;
            empty         <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            state         <= state_nxt;
            count         <= count_nxt;
            push_ack      <= ack_nxt;
            pop_valid     <= pv_nxt;
            pop_move      <= pm_nxt;
            rewind_busy   <= busy_nxt;
            rewind_done   <= done_nxt;
            full          <= (count_nxt == DepthC);
            empty         <= (count_nxt == '0);
            overflow_err  <= ovf_nxt;
            underflow_err <= unf_nxt;
        end
    end

endmodule

// File: tb/tb_move_stack_ctrl.sv
// Scoreboarded random and directed test of move_stack_ctrl against a queue-based model.
module tb_move_stack_ctrl;

    localparam int DEPTH = 32;

    logic       clk = 1'b0;
    logic       resetn = 1'b1;
    logic       push_req = 1'b0, pop_req = 1'b0, rewind_req = 1'b0;
    logic [2:0] push_move = '0;
    logic       push_ack, pop_valid, rewind_busy, rewind_done;
    logic [2:0] pop_move;
    logic [5:0] count;
    logic       full, empty, overflow_err, underflow_err;

    move_stack_ctrl dut (
        .clk(clk), .resetn(resetn),
        .push_req(push_req), .push_move(push_move), .pop_req(pop_req),
        .rewind_req(rewind_req),
        .push_ack(push_ack), .pop_valid(pop_valid), .pop_move(pop_move),
        .rewind_busy(rewind_busy), .rewind_done(rewind_done), .count(count),
        .full(full), .empty(empty), .overflow_err(overflow_err),
        .underflow_err(underflow_err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model state
    logic [2:0]  stk[$];
    int          mode = 0;  // 0 idle, 1 draining, 2 done pulse
    logic [2:0]  m_pm = '0;
    logic        m_ovf = 1'b0, m_unf = 1'b0;
    logic [16:0] sb[$];

    function automatic logic [16:0] dut_vec();
        return {push_ack, pop_valid, pop_move, rewind_busy, rewind_done, count,
                full, empty, overflow_err, underflow_err};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, want);
    endtask

    task automatic model_reset();
        stk.delete();
        mode  = 0;
        m_pm  = '0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
    endtask

    task automatic model_step(input logic p, input logic [2:0] mv, input logic pp,
                              input logic rw, output logic [16:0] e);
        logic ack, pv, busy, done;
        ack = 0; pv = 0; busy = 0; done = 0;
        case (mode)
            0: begin
                if (rw) begin
                    if (stk.size() == 0) done = 1;
                    else begin m_pm = stk.pop_back(); pv = 1; busy = 1; mode = 1; end
                end else if (p && pp) begin
                    ack = 1;
                    if (stk.size() == 0) begin stk.push_back(mv); m_unf = 1; end
                    else begin m_pm = stk.pop_back(); pv = 1; stk.push_back(mv); end
                end else if (p) begin
                    if (stk.size() == DEPTH) m_ovf = 1;
                    else begin stk.push_back(mv); ack = 1; end
                end else if (pp) begin
                    if (stk.size() == 0) m_unf = 1;
                    else begin m_pm = stk.pop_back(); pv = 1; end
                end
            end
            1: begin
                if (stk.size() > 0) begin m_pm = stk.pop_back(); pv = 1; busy = 1; end
                else begin done = 1; mode = 2; end
            end
            default: mode = 0;
        endcase
        e = {ack, pv, m_pm, busy, done, 6'(stk.size()), stk.size() == DEPTH,
             stk.size() == 0, m_ovf, m_unf};
    endtask

    // Drive one request set, queue its expected response, advance to the next negedge.
    task automatic cycle(input logic p, input logic [2:0] mv, input logic pp, input logic rw);
        logic [16:0] e;
        push_req = p; push_move = mv; pop_req = pp; rewind_req = rw;
        model_step(p, mv, pp, rw, e);
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        push_req = 0; pop_req = 0; rewind_req = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 3'd0, 0, 0);
    endtask

    always @(posedge clk) begin
        logic [16:0] e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("outputs", {15'd0, dut_vec()}, {15'd0, e});
        end
    end

    initial begin
        #2 resetn = 1'b0;
        #1 chk("reset_outputs", {15'd0, dut_vec()}, 32'd0);
        model_reset();
        @(negedge clk);
        resetn = 1'b1;

        // Underflow on empty, then push+pop on empty
        cycle(0, 3'd0, 1, 0);
        chk("underflow_set", {31'd0, underflow_err}, 32'd1);
        cycle(1, 3'd3, 1, 0);
        chk("pushpop_empty_count", {26'd0, count}, 32'd1);
        cycle(0, 3'd0, 1, 0);

        // LIFO order
        cycle(1, 3'd5, 0, 0); cycle(1, 3'd2, 0, 0); cycle(1, 3'd7, 0, 0);
        cycle(0, 3'd0, 1, 0); cycle(0, 3'd0, 1, 0); cycle(0, 3'd0, 1, 0);
        chk("lifo_last", {29'd0, pop_move}, 32'd5);
        chk("lifo_empty", {31'd0, empty}, 32'd1);

        // Fill, overflow, replace-top while full
        for (int i = 0; i < DEPTH; i++) cycle(1, 3'(i % 8), 0, 0);
        chk("full_flag", {31'd0, full}, 32'd1);
        cycle(1, 3'd4, 0, 0);
        chk("overflow_set", {31'd0, overflow_err}, 32'd1);
        cycle(1, 3'd1, 1, 0);
        chk("replace_pop", {29'd0, pop_move}, 32'd7);
        chk("replace_count", {26'd0, count}, 32'd32);
        cycle(0, 3'd0, 0, 1);
        idle(DEPTH + 2);

        // Rewind with requests ignored while draining
        cycle(1, 3'd4, 0, 0); cycle(1, 3'd1, 0, 0); cycle(1, 3'd6, 0, 0);
        cycle(0, 3'd0, 0, 1);
        cycle(1, 3'd2, 1, 0); cycle(1, 3'd3, 0, 0); cycle(1, 3'd5, 1, 1);
        chk("rewind_done", {31'd0, rewind_done}, 32'd1);
        idle(2);

        // Rewind beats push in the same cycle; rewind on empty
        cycle(1, 3'd2, 0, 0); cycle(1, 3'd3, 0, 0);
        cycle(1, 3'd5, 0, 1);
        idle(4);
        cycle(0, 3'd0, 0, 1);
        idle(2);

        // Randomised traffic
        for (int i = 0; i < 800; i++)
            cycle($urandom_range(0, 9) < 6, 3'($urandom), $urandom_range(0, 9) < 4,
                  $urandom_range(0, 99) < 3);
        cycle(0, 3'd0, 0, 1);
        idle(DEPTH + 3);

        // Reset in the middle of a rewind
        for (int i = 0; i < 10; i++) cycle(1, 3'($urandom), 0, 0);
        cycle(0, 3'd0, 0, 1);
        idle(3);
        resetn = 1'b0;
        #1 chk("midrewind_reset", {15'd0, dut_vec()}, 32'd0);
        model_reset();
        @(negedge clk); @(negedge clk);
        resetn = 1'b1;
        idle(12);
        chk("no_done_after_reset", {31'd0, rewind_done}, 32'd0);

        #20;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
